// File: rtl/arith_obfs_pkg.sv
// Shared definitions for the obfuscated bit-serial arithmetic blocks (adder/subtractor).
package arith_obfs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2,
        ST_LOCK = 2'd3
    } state_e;

    // The serial adder's ADD state shares the SUB encoding.
    localparam state_e ST_ADD = ST_SUB;

    localparam logic [7:0] A_MASK_DEF = 8'h64;
    localparam logic [7:0] B_MASK_DEF = 8'hBA;
    localparam logic [1:0] LOCK_DEF   = 2'd3;

endpackage

// File: rtl/serial_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bout = borrow out.
module serial_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor with scrambled operand load and key-gated LOCK/SUB control.
module sub_serial
    import arith_obfs_pkg::*;
#(
    parameter int unsigned      WIDTH  = 8,
    parameter logic [WIDTH-1:0] A_MASK = WIDTH'(A_MASK_DEF),
    parameter logic [WIDTH-1:0] B_MASK = WIDTH'(B_MASK_DEF),
    parameter logic [1:0]       LOCK   = LOCK_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       key,
    output logic [WIDTH-1:0] out,
    output logic             borrow_out,
    output logic             done
);

    localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] out_q;
    logic             borrow_q;
    logic [CW-1:0]    count_q;
    logic             diff_c;
    logic             bout_c;

    serial_sub_cell u_cell (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .bin (borrow_q),
        .d   (diff_c),
        .bout(bout_c)
    );

    // Control FSM and LSB-first shift datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            count_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en) begin
                        a_q      <= a ^ A_MASK;
                        b_q      <= b ^ B_MASK;
                        out_q    <= '0;
                        borrow_q <= 1'b0;
                        count_q  <= '0;
                        state_q  <= state_e'(LOCK);
                    end
                end
                state_e'(LOCK): begin
                    state_q <= key[0] ? ST_SUB : ST_IDLE;
                end
                ST_SUB: begin
                    out_q    <= {diff_c, out_q[WIDTH-1:1]};
                    borrow_q <= bout_c;
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    count_q  <= count_q + CW'(1);
                    // Completing the last bit wins over a dropped key[1].
                    if (count_q == LAST) begin
                        state_q <= ST_DONE;
                    end else if (!key[1]) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    if (en) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out        = out_q;
    assign borrow_out = borrow_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Directed bench for sub_serial: arithmetic reference model checked every cycle plus literal pins.
module tb_sub_serial;

    localparam int W = 8;
    localparam logic [7:0] AM = 8'h64;
    localparam logic [7:0] BM = 8'hBA;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en  = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [1:0]   key = 2'b11;
    logic [W-1:0] out;
    logic         borrow_out;
    logic         done;

    int total = 0;
    int bad   = 0;

    sub_serial dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .a         (a),
        .b         (b),
        .key       (key),
        .out       (out),
        .borrow_out(borrow_out),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=idle 1=subtracting 2=done 3=lock; k = bits processed.
    int m_ph = 0;
    int m_k  = 0;
    int m_A  = 0;
    int m_B  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph = 0; m_k = 0; m_A = 0; m_B = 0;
        end else begin
            case (m_ph)
                0: if (en) begin
                    m_A = int'(a ^ AM); m_B = int'(b ^ BM); m_k = 0; m_ph = 3;
                end
                3: m_ph = key[0] ? 1 : 0;
                1: begin
                    m_k++;
                    if (m_k == W) m_ph = 2;
                    else if (!key[1]) m_ph = 0;
                end
                default: if (en) m_ph = 0;
            endcase
        end
    end

    // Low k bits of A-B land in the top k bits of out; borrow is A<B over those k bits.
    function automatic int exp_out(input int A, input int B, input int k);
        int msk;
        if (k == 0) return 0;
        msk = (1 << k) - 1;
        return (((A - B) & msk) << (W - k)) & 8'hFF;
    endfunction

    function automatic int exp_borrow(input int A, input int B, input int k);
        int msk;
        if (k == 0) return 0;
        msk = (1 << k) - 1;
        return ((A & msk) < (B & msk)) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_out", int'(out), exp_out(m_A, m_B, m_k));
            chk("model_borrow", int'(borrow_out), exp_borrow(m_A, m_B, m_k));
            chk("model_done", int'(done), (m_ph == 2) ? 1 : 0);
        end
    end

    task automatic start(input logic [7:0] av, input logic [7:0] bv);
        a  = av;
        b  = bv;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        chk(name, seen, 1);
    endtask

    task automatic release_done();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_out", int'(out), 0);
        chk("reset_borrow", int'(borrow_out), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic: A=10, B=3, done 10 cycles after start edge
        key = 2'b11;
        start(8'h6E, 8'hB9);
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("basic_not_yet", int'(done), 0);
        @(negedge clk);
        chk("basic_latency", int'(done), 1);
        chk("basic_out", int'(out), 8'h07);
        chk("basic_borrow", int'(borrow_out), 0);
        release_done();

        // Borrow: A=3, B=5
        start(8'h67, 8'hBF);
        wait_done("borrow_wait");
        chk("borrow_out_val", int'(out), 8'hFE);
        chk("borrow_flag", int'(borrow_out), 1);
        release_done();

        // Lock reject
        key = 2'b10;
        start(8'h6E, 8'hB9);
        @(negedge clk);
        chk("lock_rej_done", int'(done), 0);
        chk("lock_rej_out", int'(out), 0);
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk("lock_rej_stay", int'(done), 0);

        // Mid-op abort on third SUB cycle, then a clean rerun
        key = 2'b11;
        start(8'h6E, 8'hB9);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        key = 2'b01;
        @(negedge clk);
        key = 2'b11;
        for (int i = 0; i < 12; i++) @(negedge clk);
        chk("abort_no_done", int'(done), 0);
        start(8'h6E, 8'hB9);
        wait_done("rerun_wait");
        chk("rerun_out", int'(out), 8'h07);

        // Back-to-back: en held through DONE, one idle cycle, then fresh load
        a  = 8'h9B;
        b  = 8'hBA;
        en = 1'b1;
        @(negedge clk);
        chk("b2b_idle_done", int'(done), 0);
        chk("b2b_idle_out", int'(out), 8'h07);
        @(negedge clk);
        chk("b2b_loaded_out", int'(out), 0);
        en = 1'b0;
        wait_done("b2b_wait");
        chk("b2b_out", int'(out), 8'hFF);
        chk("b2b_borrow", int'(borrow_out), 0);
        release_done();

        // Async reset between edges mid-SUB
        start(8'h67, 8'hBF);
        for (int i = 0; i < 5; i++) @(negedge clk);
        chk("pre_rst_out", int'(out), 8'hE0);
        #2 rst = 1'b1;
        #1;
        chk("arst_out", int'(out), 0);
        chk("arst_borrow", int'(borrow_out), 0);
        chk("arst_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start(8'h6E, 8'hB9);
        wait_done("post_rst_wait");
        chk("post_rst_out", int'(out), 8'h07);
        release_done();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
